lif_multi_neuron: RTL and testbench
===================================

# lif_multi_neuron

Parametrised leaky integrate-and-fire neuron with N weighted input channels, a serially loaded parameter set, configurable leak and an optional refractory period. It is the multi-channel successor to the single-channel LIF system and sits directly behind the TinyTapeout pin wrapper. The wrapper supplies the channel inputs, serial configuration pins and enables, and drives the spike, membrane and status outputs to pins.

## Interface
- `N_CHAN`, 2: number of input channels (1–4).
- `IN_W`, 6: width of each unsigned channel input.
- `V_W`, 8: membrane potential and threshold width.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: global enable; when 0, all state holds (config shifting included).
- `input_enable` input 1: integrate/fire step enable.
- `chan_in` input N_CHAN*IN_W: channel i at bits [i*IN_W +: IN_W], unsigned.
- `load_mode` input 1: 1 = configuration shift mode.
- `serial_data` input 1: configuration bit, sampled when load_mode=1.
- `spike_out` output 1: one-cycle spike pulse.
- `v_mem_out` output V_W: registered membrane potential.
- `params_ready` output 1: valid parameter set committed.
- `refractory_out` output 1: neuron in refractory period.

## Operation
- Config word, MSB first: {threshold[V_W], leak_shift[3], refr[4], w[N_CHAN-1][4] … w[0][4]}.
  - CFG_BITS = V_W+7+4*N_CHAN, which is 23 at defaults.
- Shift mode (load_mode=1, ena=1):
  - Each cycle, serial_data shifts into the LSB of the shadow register.
  - Bit counter increments, saturating at CFG_BITS+1.
  - params_ready is cleared.
  - Neuron is frozen: v holds, no spikes, and the refractory counter holds.
- Commit happens on the first cycle with load_mode=0 after shift mode:
  - If count == CFG_BITS: shadow is copied to the active params, params_ready=1, v=0, refractory counter=0.
  - Otherwise (short or long load): active params are unchanged, params_ready stays 0.
  - The counter is cleared in both cases.
- Step condition: ena=1, load_mode=0, params_ready=1, input_enable=1 and refractory counter=0.
- Each step:
  - sum = Σ chan_i*w_i, computed at full width.
  - leak = (leak_shift==0) ? 0 : v>>leak_shift.
  - v_next = v − leak + sum, saturated to 2^V_W−1.
- Fire when v_next > threshold (strict):
  - spike_out=1 for that cycle.
  - v=0.
  - Refractory counter is loaded with refr.
- No fire: v=v_next, spike_out=0.
- Refractory counter > 0 (whenever ena=1 and load_mode=0):
  - Counter decrements by 1.
  - v held at 0, inputs ignored, spike_out=0, refractory_out=1.
- input_enable=0: v holds; no leak is applied.
- threshold = 2^V_W−1: the neuron never fires, and v saturates at the maximum.

## Timing
- Reset values: spike_out=0, v_mem_out=0, params_ready=0, refractory_out=0; shadow, active params and counters are all 0.
- Latency: one cycle from the input sample edge to the updated v_mem_out/spike_out. All outputs are registered.
- spike_out is high for exactly one cycle per fire. refr=R gives exactly R ignored step cycles after the spike.
- Simultaneous load_mode=1 and input_enable=1: load wins and no step occurs.
- Reset asserted mid-load or mid-refractory: immediate return to reset values. A fresh config load is required afterwards.

## Configuration
- `LIF_REFRACTORY_EN` defined: refractory counter, `refr` field and refractory behaviour as above.
- Undefined:
  - `refr` is removed from the config word, so CFG_BITS = V_W+3+4*N_CHAN.
  - refractory_out is tied to 0.
  - After a fire, the neuron integrates again on the next step cycle.

## Test plan
Defaults (N_CHAN=2, IN_W=6, V_W=8), `LIF_REFRACTORY_EN` defined.
- Reset: rst_n=0 mid-run -> all outputs 0 immediately; params_ready=0 after release; input_enable=1 with chan0=30 leaves v_mem_out=0.
- Fire and refractory:
  - Load thr=100, leak=0, refr=2, w1=0, w0=1; chan0=30, input_enable=1.
  - Required: v_mem_out 30, 60, 90, then spike_out=1 with v=0 on the 4th step.
  - Then 2 cycles of refractory_out=1 with v=0, then v=30.
- Short load: 22 bits, then load_mode=0 -> params_ready stays 0 and stepping has no effect. A further 24-bit load is likewise rejected.
- Saturation: thr=255, w0=15, chan0=63 -> v_mem_out=255 after 1 step and stays 255; spike_out is never asserted.
- Leak:
  - leak_shift=1, thr=200; one step with chan0=40, then chan0=0.
  - Required: v = 40, 20, 10, 5, 3, 2, 1, 1.
- Two channels: w0=2, w1=3, chan0=5, chan1=4, thr=200, leak=0 -> v increases by 22 per step.

Source files
------------

// File: rtl/lif_multi_neuron.sv
// lif_multi_neuron: N-channel leaky integrate-and-fire neuron with a serially loaded parameter set.
// Latency: one cycle from the input sample edge to registered v_mem_out / spike_out / status outputs.
// Backpressure: none; ena=0 freezes all state, load_mode=1 freezes the neuron while config shifts in.
// Optional refractory period is built in when the macro LIF_REFRACTORY_EN is defined.
module lif_multi_neuron #(
  parameter int N_CHAN = 2,
  parameter int IN_W   = 6,
  parameter int V_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     input_enable,
  input  logic [N_CHAN*IN_W-1:0]   chan_in,
  input  logic                     load_mode,
  input  logic                     serial_data,
  output logic                     spike_out,
  output logic [V_W-1:0]           v_mem_out,
  output logic                     params_ready,
  output logic                     refractory_out
);

`ifdef LIF_REFRACTORY_EN
  localparam int REFR_W = 4;
`else
  localparam int REFR_W = 0;
`endif

  // Config word layout, LSB upwards: w[0], w[1] ... w[N_CHAN-1], (refr), leak_shift, threshold.
  localparam int CFG_BITS = V_W + 3 + REFR_W + 4 * N_CHAN;
  localparam int LEAK_LSB = 4 * N_CHAN + REFR_W;
  localparam int THR_LSB  = LEAK_LSB + 3;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS + 1);

  // Weighted sum never overflows: N_CHAN * (2^IN_W-1) * 15 < 2^(IN_W+4+clog2(N_CHAN)).
  localparam int SUM_W = IN_W + 4 + $clog2(N_CHAN);
  localparam int ACC_W = ((SUM_W > V_W) ? SUM_W : V_W) + 1;

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                rdy_q, rdy_d;
  logic [V_W-1:0]      v_q, v_d;
  logic                spike_q, spike_d;

  logic [SUM_W-1:0]    sum;
  logic [2:0]          leak_shift;
  logic [V_W-1:0]      leak_amt;
  logic [ACC_W-1:0]    acc;
  logic [V_W-1:0]      v_sat;
  logic [V_W-1:0]      thr;
  logic                fire;
  logic                commit_ok;
  logic                in_refr;
  logic                step_fire;

  // Weighted sum of all channels at full width.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      sum = sum + SUM_W'(chan_in[i*IN_W +: IN_W]) * SUM_W'(cfg_q[4*i +: 4]);
    end
  end

  assign leak_shift = cfg_q[LEAK_LSB +: 3];
  assign thr        = cfg_q[THR_LSB +: V_W];
  assign leak_amt   = (leak_shift == 3'd0) ? '0 : (v_q >> leak_shift);

  // v - leak is never negative, so only the upper saturation bound matters.
  assign acc   = ACC_W'(v_q) - ACC_W'(leak_amt) + ACC_W'(sum);
  assign v_sat = (acc[ACC_W-1:V_W] != '0) ? {V_W{1'b1}} : acc[V_W-1:0];
  assign fire  = (v_sat > thr);

  // A nonzero bit count with load_mode low marks the first cycle after shifting.
  assign commit_ok = ena && !load_mode && (bit_cnt_q == CNT_OK);
  assign step_fire = ena && !load_mode && !commit_ok && !in_refr &&
                     rdy_q && input_enable && fire;

  // Next state for config shifting, commit and the integrate/fire step.
  always_comb begin
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    cfg_d     = cfg_q;
    rdy_d     = rdy_q;
    v_d       = v_q;
    spike_d   = 1'b0;
    if (ena) begin
      if (load_mode) begin
        shadow_d = {shadow_q[CFG_BITS-2:0], serial_data};
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        rdy_d = 1'b0;
      end else begin
        bit_cnt_d = '0;
        if (commit_ok) begin
          cfg_d = shadow_q;
          rdy_d = 1'b1;
          v_d   = '0;
        end else if (in_refr) begin
          v_d = '0;
        end else if (rdy_q && input_enable) begin
          spike_d = fire;
          v_d     = fire ? '0 : v_sat;
        end
      end
    end
  end

  // Datapath and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      cfg_q     <= '0;
      bit_cnt_q <= '0;
      rdy_q     <= 1'b0;
      v_q       <= '0;
      spike_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      cfg_q     <= cfg_d;
      bit_cnt_q <= bit_cnt_d;
      rdy_q     <= rdy_d;
      v_q       <= v_d;
      spike_q   <= spike_d;
    end
  end

`ifdef LIF_REFRACTORY_EN
  logic [3:0] refr_cnt_q, refr_cnt_d;
  logic       refr_out_q, refr_out_d;
  logic [3:0] refr_val;

  assign refr_val = cfg_q[4*N_CHAN +: 4];
  assign in_refr  = (refr_cnt_q != 4'd0);

  // Refractory countdown: each ignored step cycle is flagged on refractory_out.
  always_comb begin
    refr_cnt_d = refr_cnt_q;
    refr_out_d = refr_out_q;
    if (ena && !load_mode) begin
      if (commit_ok) begin
        refr_cnt_d = 4'd0;
        refr_out_d = 1'b0;
      end else if (in_refr) begin
        refr_cnt_d = refr_cnt_q - 4'd1;
        refr_out_d = 1'b1;
      end else begin
        refr_out_d = 1'b0;
        if (step_fire) begin
          refr_cnt_d = refr_val;
        end
      end
    end
  end

  // Refractory state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refr_cnt_q <= 4'd0;
      refr_out_q <= 1'b0;
    end else begin
      refr_cnt_q <= refr_cnt_d;
      refr_out_q <= refr_out_d;
    end
  end

  assign refractory_out = refr_out_q;
`else
  // Without refractory support the neuron integrates again right after a fire.
  logic unused_step_fire;
  assign unused_step_fire = step_fire;
  assign in_refr          = 1'b0;
  assign refractory_out   = 1'b0;
`endif

  assign spike_out    = spike_q;
  assign v_mem_out    = v_q;
  assign params_ready = rdy_q;

endmodule

// File: tb/tb_lif_multi_neuron.sv
// Testbench for lif_multi_neuron: directed vectors, a cycle model of the neuron rules,
// a negedge compare process and hand-computed literal expectations.
module tb_lif_multi_neuron;
  localparam int N_CHAN = 2;
  localparam int IN_W   = 6;
  localparam int V_W    = 8;
  localparam int VMAX   = (1 << V_W) - 1;
`ifdef LIF_REFRACTORY_EN
  localparam int RW      = 4;
  localparam bit REFR_EN = 1'b1;
`else
  localparam int RW      = 0;
  localparam bit REFR_EN = 1'b0;
`endif
  localparam int CFG_BITS = V_W + 3 + RW + 4 * N_CHAN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic input_enable = 1'b0;
  logic load_mode = 1'b0;
  logic serial_data = 1'b0;
  logic [N_CHAN*IN_W-1:0] chan_in = '0;
  logic spike_out, params_ready, refractory_out;
  logic [V_W-1:0] v_mem_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_v, m_thr, m_leak, m_refr_val, m_refr;
  int m_w[N_CHAN];
  bit m_rdy, m_spike, m_refr_out;
  bit sh[$];

  lif_multi_neuron #(.N_CHAN(N_CHAN), .IN_W(IN_W), .V_W(V_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .input_enable(input_enable),
    .chan_in(chan_in), .load_mode(load_mode), .serial_data(serial_data),
    .spike_out(spike_out), .v_mem_out(v_mem_out),
    .params_ready(params_ready), .refractory_out(refractory_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_v = 0; m_thr = 0; m_leak = 0; m_refr_val = 0; m_refr = 0;
    for (int i = 0; i < N_CHAN; i++) m_w[i] = 0;
    m_rdy = 0; m_spike = 0; m_refr_out = 0;
    sh.delete();
  endtask

  // Applies the neuron rules for one rising edge using the current inputs.
  task automatic model_step();
    longint word;
    int sum, nv, lk;
    bit ok;
    m_spike = 0;
    if (!ena) return;
    if (load_mode) begin
      sh.push_back(serial_data);
      m_rdy = 0;
      return;
    end
    ok = (sh.size() == CFG_BITS);
    if (ok) begin
      word = 0;
      foreach (sh[i]) word = (word << 1) | longint'(sh[i]);
      for (int i = 0; i < N_CHAN; i++) m_w[i] = int'((word >> (4 * i)) & 15);
      m_refr_val = int'((word >> (4 * N_CHAN)) & 15);
      m_leak     = int'((word >> (4 * N_CHAN + RW)) & 7);
      m_thr      = int'((word >> (4 * N_CHAN + RW + 3)) & VMAX);
      m_rdy = 1; m_v = 0; m_refr = 0; m_refr_out = 0;
    end
    sh.delete();
    if (ok) return;
    if (m_refr > 0) begin
      m_refr--;
      m_v = 0;
      m_refr_out = 1;
      return;
    end
    m_refr_out = 0;
    if (m_rdy && input_enable) begin
      sum = 0;
      for (int i = 0; i < N_CHAN; i++) sum += int'(chan_in[i*IN_W +: IN_W]) * m_w[i];
      lk = (m_leak == 0) ? 0 : (m_v >> m_leak);
      nv = m_v - lk + sum;
      if (nv > VMAX) nv = VMAX;
      if (nv > m_thr) begin
        m_spike = 1;
        m_v = 0;
        if (REFR_EN) m_refr = m_refr_val;
      end else begin
        m_v = nv;
      end
    end
  endtask

  // Every settled cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cmp_spike", int'(spike_out), int'(m_spike));
      check("cmp_v", int'(v_mem_out), m_v);
      check("cmp_ready", int'(params_ready), int'(m_rdy));
      check("cmp_refr", int'(refractory_out), int'(m_refr_out));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  function automatic longint cfg_word(input int thr, input int leak, input int refr,
                                      input int w1, input int w0);
    longint word;
    word = longint'(thr);
    word = (word << 3) | longint'(leak);
    if (RW != 0) word = (word << 4) | longint'(refr);
    word = (word << 4) | longint'(w1);
    word = (word << 4) | longint'(w0);
    return word;
  endfunction

  // Shift n bits MSB first, then one load_mode=0 cycle to commit.
  task automatic shift_bits(input longint word, input int n);
    load_mode = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      serial_data = word[i];
      tick();
    end
    load_mode = 1'b0;
    serial_data = 1'b0;
    tick();
  endtask

  task automatic set_chan(input int c1, input int c0);
    chan_in = {IN_W'(c1), IN_W'(c0)};
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_spike", int'(spike_out), 0);
    check("rst_v", int'(v_mem_out), 0);
    check("rst_ready", int'(params_ready), 0);
    check("rst_refr", int'(refractory_out), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int leak_exp[8];
    leak_exp = '{40, 20, 10, 5, 3, 2, 1, 1};
    m_reset();
    #12;
    check("por_spike", int'(spike_out), 0);
    check("por_v", int'(v_mem_out), 0);
    check("por_ready", int'(params_ready), 0);
    check("por_refr", int'(refractory_out), 0);
    rst_n = 1'b1;
    ena = 1'b1;
    chk_en = 1'b1;

    // No parameters yet: stepping does nothing
    input_enable = 1'b1;
    set_chan(0, 30);
    tick(); tick();
    check("noparam_v", int'(v_mem_out), 0);
    check("noparam_ready", int'(params_ready), 0);

    // Short then long loads are rejected
    shift_bits(cfg_word(100, 0, 2, 0, 1), CFG_BITS - 1);
    check("short_ready", int'(params_ready), 0);
    tick();
    check("short_v", int'(v_mem_out), 0);
    shift_bits(cfg_word(100, 0, 2, 0, 1), CFG_BITS + 1);
    check("long_ready", int'(params_ready), 0);
    tick();
    check("long_v", int'(v_mem_out), 0);

    // Fire and refractory; input_enable stays high during the load (load wins)
    shift_bits(cfg_word(100, 0, 2, 0, 1), CFG_BITS);
    check("fire_ready", int'(params_ready), 1);
    check("fire_v0", int'(v_mem_out), 0);
    tick(); check("fire_v30", int'(v_mem_out), 30);
    tick(); check("fire_v60", int'(v_mem_out), 60);
    tick(); check("fire_v90", int'(v_mem_out), 90);
    tick(); check("fire_spike", int'(spike_out), 1); check("fire_vz", int'(v_mem_out), 0);
`ifdef LIF_REFRACTORY_EN
    tick(); check("refr1_out", int'(refractory_out), 1); check("refr1_v", int'(v_mem_out), 0);
    check("refr1_spike", int'(spike_out), 0);
    tick(); check("refr2_out", int'(refractory_out), 1); check("refr2_v", int'(v_mem_out), 0);
    tick(); check("refr_end_out", int'(refractory_out), 0); check("refr_end_v", int'(v_mem_out), 30);
`else
    tick(); check("after_fire_v", int'(v_mem_out), 30); check("after_fire_refr", int'(refractory_out), 0);
`endif

    // Reset mid-refractory, then a fresh load is required
    tick(); tick(); tick();
    check("refire_spike", int'(spike_out), 1);
    tick();
    assert_reset();
    tick();
    check("post_rst_ready", int'(params_ready), 0);
    tick();
    check("post_rst_v", int'(v_mem_out), 0);

    // Reset mid-load leaves no pending commit
    load_mode = 1'b1;
    repeat (10) begin serial_data = 1'b1; tick(); end
    assert_reset();
    load_mode = 1'b0;
    serial_data = 1'b0;
    tick();
    check("midload_ready", int'(params_ready), 0);

    // Saturation with threshold at maximum
    set_chan(0, 63);
    shift_bits(cfg_word(255, 0, 0, 0, 15), CFG_BITS);
    repeat (5) begin
      tick();
      check("sat_v", int'(v_mem_out), 255);
      check("sat_spike", int'(spike_out), 0);
    end

    // Leak by shift of one
    input_enable = 1'b0;
    shift_bits(cfg_word(200, 1, 0, 0, 1), CFG_BITS);
    input_enable = 1'b1;
    set_chan(0, 40);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("leak_v", int'(v_mem_out), leak_exp[i]);
      set_chan(0, 0);
    end
    input_enable = 1'b0;
    tick(); tick();
    check("hold_v", int'(v_mem_out), 1);

    // Two channels
    input_enable = 1'b1;
    set_chan(4, 5);
    shift_bits(cfg_word(200, 0, 0, 3, 2), CFG_BITS);
    tick(); check("two_v22", int'(v_mem_out), 22);
    tick(); check("two_v44", int'(v_mem_out), 44);
    ena = 1'b0;
    tick(); tick();
    check("ena_hold_v", int'(v_mem_out), 44);
    ena = 1'b1;
    tick(); check("two_v66", int'(v_mem_out), 66);
    tick(); check("two_v88", int'(v_mem_out), 88);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
